// File: rtl/b09_lane_scheduler.sv
// Round-robin scheduler sharing one serial compare/convert path among NLANES
// serial requesters; a frame is re-serialised on y only if it differs from that lane's last word.
module b09_lane_old #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clock or posedge reset)
    if (reset)   q <= '0;
    else if (we) q <= d;
endmodule

module b09_lane_scheduler #(
  parameter int NLANES = 4,
  parameter int DW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NLANES-1:0] lane_req,
  input  logic [NLANES-1:0] lane_x,
  output logic [NLANES-1:0] lane_grant,
  output logic              y,
  output logic              y_valid,
  output logic [2:0]        y_lane,
  output logic              busy,
  output logic [7:0]        supp_cnt
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RECV, CMP, SEND} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d, rr_q, rr_d, pick, nxt_sel;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [NLANES-1:0] grant_d, old_we;
  logic              y_d, yv_d, busy_d;
  logic [2:0]        ylane_d;
  logic [7:0]        supp_d;

  // Lane vectors widened to 8 so a 3-bit lane index never overruns them.
  logic [7:0]         req8, x8;
  logic [7:0][DW-1:0] old8;

  assign req8 = 8'(lane_req);
  assign x8   = 8'(lane_x);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_old
      if (gi < NLANES) begin : g_lane
        b09_lane_old #(.DW(DW)) u_old (
          .clock (clock),
          .reset (reset),
          .we    (old_we[gi]),
          .d     (shreg_q),
          .q     (old8[gi])
        );
      end else begin : g_pad
        assign old8[gi] = '0;
      end
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    logic found;
    logic [2:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NLANES; k++) begin
      idx = 3'((int'(rr_q) + k) % NLANES);
      if (!found && req8[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign nxt_sel = (sel_q == 3'(NLANES - 1)) ? 3'd0 : sel_q + 3'd1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    grant_d = lane_grant;
    y_d     = 1'b0;
    yv_d    = 1'b0;
    ylane_d = y_lane;
    supp_d  = supp_cnt;
    old_we  = '0;
    case (state_q)
      IDLE: if (|lane_req) begin
        sel_d = pick;
        for (int i = 0; i < NLANES; i++) grant_d[i] = (3'(i) == pick);
        cnt_d   = '0;
        state_d = RECV;
      end
      RECV: if (!req8[sel_q]) begin
        // Aborted frame: partial word discarded, lane loses its turn.
        grant_d = '0;
        rr_d    = nxt_sel;
        state_d = IDLE;
      end else begin
        shreg_d = {shreg_q[DW-2:0], x8[sel_q]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          grant_d = '0;
          state_d = CMP;
        end
      end
      CMP: if (shreg_q != old8[sel_q]) begin
        for (int i = 0; i < NLANES; i++) old_we[i] = (3'(i) == sel_q);
        yv_d    = 1'b1;
        y_d     = shreg_q[DW-1];
        ylane_d = sel_q;
        shreg_d = shreg_q << 1;
        cnt_d   = '0;
        state_d = SEND;
      end else begin
        supp_d  = (supp_cnt == 8'hFF) ? supp_cnt : supp_cnt + 8'd1;
        rr_d    = nxt_sel;
        state_d = IDLE;
      end
      SEND: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          rr_d    = nxt_sel;
          state_d = IDLE;
        end else begin
          yv_d    = 1'b1;
          y_d     = shreg_q[DW-1];
          shreg_d = shreg_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      lane_grant <= '0;
      y          <= 1'b0;
      y_valid    <= 1'b0;
      y_lane     <= '0;
      busy       <= 1'b0;
      supp_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      lane_grant <= grant_d;
      y          <= y_d;
      y_valid    <= yv_d;
      y_lane     <= ylane_d;
      busy       <= busy_d;
      supp_cnt   <= supp_d;
    end
  end
endmodule
